// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage condition unit.
// The optional performance counters are enabled by the COND_PERF_CNT_EN macro.
package cond_pkg;

    // Default width of the flag vector {Z,N,C,V}.
    localparam int unsigned FLAGS_W_DEF = 4;

    // Bit positions inside the flag vector, matching the ALU flag output order.
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // ARM condition field encodings (Instr[31:28]).
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Contents of the execute-to-next-stage pipeline register.
    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_write;
        logic cond_ex;
        logic illegal;
    } pipe_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit ARM condition field against {Z,N,C,V}.
// Encoding 4'b1111 never passes and is reported as illegal.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass,
    output logic       illegal
);

    logic z, n, c, v;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field into a pass/fail decision.
    always_comb begin
        pass    = 1'b0;
        illegal = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: illegal = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: architectural flag register, condition
// evaluation, write-control gating and one pipeline register with
// flush > stall > normal priority.
// Define COND_PERF_CNT_EN to add saturating exec/squash performance counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int unsigned FLAGS_W = FLAGS_W_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [3:0]         cond,
    input  logic [1:0]         flag_w,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic               pc_src_in,
    input  logic               reg_write_in,
    input  logic               mem_write_in,
    output logic               pc_src_out,
    output logic               reg_write_out,
    output logic               mem_write_out,
    output logic               cond_ex_out,
    output logic               illegal_cond_out,
`ifdef COND_PERF_CNT_EN
    output logic [CNT_W-1:0]   exec_cnt,
    output logic [CNT_W-1:0]   squash_cnt,
`endif
    output logic [FLAGS_W-1:0] flags_q
);

    logic               cond_pass;
    logic               cond_illegal;
    logic               cond_ex;
    logic               advance;
    logic [FLAGS_W-1:0] flags_d;
    pipe_t              pipe_d;
    pipe_t              pipe_q;

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q[3:0]),
        .pass    (cond_pass),
        .illegal (cond_illegal)
    );

    assign cond_ex = in_valid & cond_pass;
    assign advance = !stall & !flush;

    // Next flag state: only an executed, non-stalled, non-flushed instruction writes.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && advance) begin
            if (flag_w[1]) begin
                flags_d[FLAG_Z] = alu_flags[FLAG_Z];
                flags_d[FLAG_N] = alu_flags[FLAG_N];
            end
            if (flag_w[0]) begin
                flags_d[FLAG_C] = alu_flags[FLAG_C];
                flags_d[FLAG_V] = alu_flags[FLAG_V];
            end
        end
    end

    // Next pipeline register contents: flush clears, stall holds, otherwise gated controls.
    always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
            pipe_d = '0;
        end else if (!stall) begin
            pipe_d.pc_src    = pc_src_in & cond_ex;
            pipe_d.reg_write = reg_write_in & cond_ex;
            pipe_d.mem_write = mem_write_in & cond_ex;
            pipe_d.cond_ex   = cond_ex;
            pipe_d.illegal   = in_valid & cond_illegal;
        end
    end

    // Flag and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            pipe_q  <= '0;
        end else begin
            flags_q <= flags_d;
            pipe_q  <= pipe_d;
        end
    end

    assign pc_src_out       = pipe_q.pc_src;
    assign reg_write_out    = pipe_q.reg_write;
    assign mem_write_out    = pipe_q.mem_write;
    assign cond_ex_out      = pipe_q.cond_ex;
    assign illegal_cond_out = pipe_q.illegal;

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_d, exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_d, squash_cnt_q;

    // Saturating counters of executed vs squashed valid instructions.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (advance && in_valid) begin
            if (cond_ex) begin
                if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + CNT_W'(1);
            end else begin
                if (squash_cnt_q != '1) squash_cnt_d = squash_cnt_q + CNT_W'(1);
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage consumer of the ALU's result flags.
- Holds the architectural flag register and evaluates the 4-bit ARM condition field against the current flags.
- Gates the PC-write, register-write and memory-write controls, and hands them to the next stage through one pipeline register with stall and flush support.

Parameters:
FLAGS_W, 4, flag vector width; bit 3=Z, 2=N, 1=C, 0=V (matches ALU flag output order)
CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  an instruction is present in execute this cycle
stall  in  1  hold pipeline register and flags
flush  in  1  squash the instruction currently in execute
cond  in  4  condition field Instr[31:28]
flag_w  in  2  [1]: update Z,N; [0]: update C,V
alu_flags  in  FLAGS_W  {Z,N,C,V} from the ALU
pc_src_in  in  1  ungated PC-write request
reg_write_in  in  1  ungated register-write request
mem_write_in  in  1  ungated memory-write request
pc_src_out  out  1  registered gated PC-write
reg_write_out  out  1  registered gated register-write
mem_write_out  out  1  registered gated memory-write
cond_ex_out  out  1  registered: instruction executed
illegal_cond_out  out  1  registered: cond==4'b1111 seen with in_valid
flags_q  out  FLAGS_W  architectural flags {Z,N,C,V}

Behaviour:
- Reset, asynchronous on assert of reset:
  - flags_q=4'b0000.
  - All registered outputs 0.
  - Counters (if present) 0.
- cond_ex is combinational: cond_ex = in_valid & check(cond, flags_q). Evaluation uses the flags before this instruction's own update.
- check table:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0, and flagged illegal
- Flag update at rising clk, only if cond_ex & !stall & !flush:
  - flag_w[1] loads Z,N from alu_flags[3:2].
  - flag_w[0] loads C,V from alu_flags[1:0].
  - Bits not enabled hold their value.
- Pipeline register, one cycle of latency, priority flush > stall > normal:
  - flush: register loads all zeros; flags not updated.
  - stall (no flush): register and flags hold.
  - normal: pc_src_out=pc_src_in&cond_ex, reg_write_out=reg_write_in&cond_ex, mem_write_out=mem_write_in&cond_ex, cond_ex_out=cond_ex, illegal_cond_out=in_valid&(cond==4'b1111).
- in_valid=0 (no flush/stall): register loads zeros, flags hold.
- Back-to-back instructions: flags written at edge k are visible to the instruction in execute during cycle k+1. No bypass is required.
- Reset asserted mid-operation clears everything immediately. The first instruction after deassert sees flags 0000.

Optional Feature:
- Macro COND_PERF_CNT_EN.
- Defined:
  - Adds outputs exec_cnt and squash_cnt, each CNT_W wide, saturating at all-ones.
  - On each non-stalled, non-flushed cycle with in_valid=1, exec_cnt increments if cond_ex=1; otherwise squash_cnt increments.
  - Flushed and stalled cycles do not count.
  - Both counters reset to 0.
- Undefined: counter ports and logic absent; all other behaviour identical.

Decomposition:
- Package cond_pkg:
  - cond_e enum (16 encodings above).
  - Flag bit index localparams FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - FLAGS_W default.
- One combinational sub-module, cond_check: cond[3:0] and flags[3:0] in; pass and illegal out. Instantiated once.
- Flag register, pipeline register and counters stay in cond_unit.

Test Plan:
- Reset mid-run with flags_q=4'b1111 -> flags_q=0000 and all outputs 0 immediately (asynchronous), before the next edge.
- flags_q=0000, cond=EQ(0000), reg_write_in=1, flag_w=2'b11, alu_flags=4'b1000 -> next edge: reg_write_out=0, cond_ex_out=0, flags_q stays 0000.
- cond=AL, flag_w=2'b10, alu_flags=4'b1011 -> flags_q=1000 (C,V held at 0). Next cycle cond=EQ, mem_write_in=1 -> mem_write_out=1 after one edge.
- flags_q=0101 (N=1,V=1): cond=GE -> cond_ex_out=1; cond=LT -> 0; cond=GT -> 1; cond=LE -> 0. Each result appears one edge later.
- stall=1 for 3 cycles with cond=AL, flag_w=2'b11, alu_flags=4'b0110 -> outputs and flags_q frozen. Then flush=1 together with stall=1 -> outputs 0, flags_q unchanged.
- cond=4'b1111, in_valid=1, pc_src_in=1 -> pc_src_out=0, illegal_cond_out=1 for one cycle. With COND_PERF_CNT_EN: squash_cnt +1; exec_cnt from 32'hFFFFFFFF stays saturated on an AL instruction.
